// File: rtl/pll_rst_pkg.sv
// Shared types and constants for the PLL reset supervisor.
package pll_rst_pkg;

  // Supervisor sequence states.
  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_e;

  // Width of the retry and lock-loss status counters.
  localparam int CNT8_W = 8;

  // Largest of three cycle counts; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_ff2.sv
// N-stage flop synchronizer for a single asynchronous bit, async active-high reset to 0.
module sync_ff2 #(
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  // Shift the asynchronous input through N flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[N-2:0], d_i};
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset supervisor: pulses the PLL reset, waits for a synchronized lock,
// retries on lock timeout and releases the system reset after lock is stable.
// Optional feature macro PLL_LOSS_CNT_EN adds loss_cnt, a count of lock losses in RUN.
module pll_reset_ctrl
  import pll_rst_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 27000,
  parameter int STABLE_CYCLES  = 2700,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              soft_reset,
  input  logic              lock,
  output logic              pll_reset,
  output logic              sys_reset,
  output logic              ready,
  output logic              timeout_err,
  output logic [CNT8_W-1:0] retry_cnt
`ifdef PLL_LOSS_CNT_EN
  ,
  output logic [CNT8_W-1:0] loss_cnt
`endif
);

  localparam int CNT_W = $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lock_s;
  logic              timeout_ev;
  logic              sys_reset_q, ready_q, terr_q;
  logic [CNT8_W-1:0] retry_q;

  sync_ff2 #(.N(SYNC_STAGES)) u_lock_sync (
    .clk_i (clkin),
    .rst_i (reset),
    .d_i   (lock),
    .q_o   (lock_s)
  );

  // Next state and phase counter; soft_reset overrides any other event.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    timeout_ev = 1'b0;
    unique case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) state_d = STABLE;
        else if (cnt_q == TO_LAST) begin
          state_d    = PLL_RST;
          timeout_ev = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s) state_d = WAIT_LOCK;
        else if (cnt_q == STB_LAST) state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q;
        if (!lock_s) state_d = WAIT_LOCK;
      end
      default: state_d = PLL_RST;
    endcase
    if (soft_reset) begin
      state_d    = PLL_RST;
      timeout_ev = 1'b0;
    end
    if (soft_reset || (state_d != state_q)) cnt_d = '0;
  end

  // State and counter registers.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q <= PLL_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered status: reset release follows RUN by one cycle; sticky timeout and retry count.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      terr_q      <= 1'b0;
      retry_q     <= '0;
    end else begin
      sys_reset_q <= (state_q != RUN);
      ready_q     <= (state_q == RUN);
      if (soft_reset) begin
        terr_q  <= 1'b0;
        retry_q <= '0;
      end else if (timeout_ev) begin
        terr_q <= 1'b1;
        if (retry_q != '1) retry_q <= retry_q + CNT8_W'(1);
      end
    end
  end

`ifdef PLL_LOSS_CNT_EN
  logic              loss_ev;
  logic [CNT8_W-1:0] loss_q;

  assign loss_ev = (state_q == RUN) && !lock_s;

  // Saturating count of lock losses while running.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset)                         loss_q <= '0;
    else if (soft_reset)               loss_q <= '0;
    else if (loss_ev && loss_q != '1)  loss_q <= loss_q + CNT8_W'(1);
  end

  assign loss_cnt = loss_q;
`endif

  assign pll_reset   = (state_q == PLL_RST);
  assign sys_reset   = sys_reset_q;
  assign ready       = ready_q;
  assign timeout_err = terr_q;
  assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl with a phase/elapsed-time reference model.
module tb_pll_reset_ctrl;

  localparam int PR = 4;
  localparam int TO = 20;
  localparam int ST = 8;
  localparam int SS = 2;

  logic       clkin = 1'b0;
  logic       reset = 1'b0;
  logic       soft_reset = 1'b0;
  logic       lock = 1'b0;
  logic       pll_reset, sys_reset, ready, timeout_err;
  logic [7:0] retry_cnt;
`ifdef PLL_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  pll_reset_ctrl #(
    .PLL_RST_CYCLES(PR), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(ST), .SYNC_STAGES(SS)
  ) dut (
    .clkin       (clkin),
    .reset       (reset),
    .soft_reset  (soft_reset),
    .lock        (lock),
    .pll_reset   (pll_reset),
    .sys_reset   (sys_reset),
    .ready       (ready),
    .timeout_err (timeout_err),
    .retry_cnt   (retry_cnt)
`ifdef PLL_LOSS_CNT_EN
    ,
    .loss_cnt    (loss_cnt)
`endif
  );

  always #5 clkin = ~clkin;
  always @(posedge clkin) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: phase 0=PLL held in reset, 1=waiting for lock, 2=qualifying, 3=running.
  // m_e counts cycles already spent in the phase; lock reaches the sequencer after SS flops.
  int         m_p = 0, m_e = 0, m_retry = 0, m_loss = 0;
  bit         m_terr = 1'b0, m_sys = 1'b1;
  logic [SS-1:0] m_sh = '0;

  always @(posedge clkin or posedge reset) begin : model
    int p, e;
    bit ls;
    if (reset) begin
      m_p <= 0; m_e <= 0; m_retry <= 0; m_loss <= 0;
      m_terr <= 1'b0; m_sys <= 1'b1; m_sh <= '0;
    end else begin
      ls = m_sh[SS-1];
      p  = m_p;
      e  = m_e;
      m_sys <= (m_p != 3);
      m_sh  <= {m_sh[SS-2:0], lock};
      if (soft_reset) begin
        p = 0; e = 0;
        m_retry <= 0; m_terr <= 1'b0; m_loss <= 0;
      end else begin
        case (p)
          0: begin
            e++;
            if (e == PR) begin p = 1; e = 0; end
          end
          1: begin
            if (ls) begin p = 2; e = 0; end
            else begin
              e++;
              if (e == TO) begin
                p = 0; e = 0;
                m_terr  <= 1'b1;
                m_retry <= (m_retry < 255) ? m_retry + 1 : 255;
              end
            end
          end
          2: begin
            if (!ls) begin p = 1; e = 0; end
            else begin
              e++;
              if (e == ST) begin p = 3; e = 0; end
            end
          end
          default: begin
            if (!ls) begin
              p = 1; e = 0;
              m_loss <= (m_loss < 255) ? m_loss + 1 : 255;
            end
          end
        endcase
      end
      m_p <= p;
      m_e <= e;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clkin) begin
    if (chk_en) begin
      chk("pll_reset", pll_reset, (m_p == 0));
      chk("sys_reset", sys_reset, m_sys);
      chk("ready", ready, !m_sys);
      chk("timeout_err", timeout_err, m_terr);
      chk("retry_cnt", retry_cnt, m_retry);
`ifdef PLL_LOSS_CNT_EN
      chk("loss_cnt", loss_cnt, m_loss);
`endif
    end
  end

  // Wait (bounded) until pll_reset reaches lvl; sampled 1 time unit after each edge.
  task automatic wait_pll(input logic lvl, input string nm);
    int n = 0;
    while (pll_reset !== lvl && n < 200) begin
      @(posedge clkin); #1; n++;
    end
    chk(nm, pll_reset, lvl);
  endtask

  // Edges from the lock-capturing edge until sys_reset reaches lvl (bounded).
  task automatic count_sys(input logic lvl, output int n);
    n = 0;
    @(posedge clkin);
    do begin
      @(posedge clkin); #1; n++;
    end while (sys_reset !== lvl && n < 200);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int n, t0, t1;
    #1 reset = 1'b1;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clkin);
    #1;
    chk("rst_pll_reset", pll_reset, 1);
    chk("rst_sys_reset", sys_reset, 1);
    chk("rst_ready", ready, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_retry_cnt", retry_cnt, 0);

    // 1: PLL reset width and lock-to-release latency.
    @(negedge clkin) reset = 1'b0;
    n = 0;
    do begin @(posedge clkin); #1; n++; end while (pll_reset !== 1'b0 && n < 200);
    chk("t1_pll_high_cycles", n, PR);
    repeat (2) @(posedge clkin);
    @(negedge clkin) lock = 1'b1;
    count_sys(1'b0, n);
    chk("t1_release_latency", n, SS + ST + 1);
    chk("t1_ready", ready, 1);

    // 4: lock loss in RUN.
    @(negedge clkin) lock = 1'b0;
    @(posedge clkin);
    n = 0;
    do begin @(posedge clkin); #1; n++; end while ((sys_reset !== 1'b1 || ready !== 1'b0) && n < 200);
    chk("t4_loss_latency", n, 3);
`ifdef PLL_LOSS_CNT_EN
    chk("t4_loss_cnt", loss_cnt, 1);
`endif

    // 2: lock held low -> periodic PLL retries.
    wait_pll(1'b1, "t2_first_retry");
    t0 = cyc;
    chk("t2_retry1", retry_cnt, 1);
    chk("t2_terr", timeout_err, 1);
    wait_pll(1'b0, "t2_fall");
    wait_pll(1'b1, "t2_second_retry");
    t1 = cyc;
    chk("t2_period1", t1 - t0, PR + TO);
    chk("t2_retry2", retry_cnt, 2);
    wait_pll(1'b0, "t2_fall2");
    wait_pll(1'b1, "t2_third_retry");
    chk("t2_period2", cyc - t1, PR + TO);
    chk("t2_retry3", retry_cnt, 3);

    // 3: lock glitch during qualification.
    wait_pll(1'b0, "t3_fall");
    @(negedge clkin) lock = 1'b1;
    @(posedge clkin);
    repeat (5) @(posedge clkin);
    @(negedge clkin) lock = 1'b0;
    repeat (2) @(posedge clkin);
    #1 chk("t3_sys_held", sys_reset, 1);
    @(negedge clkin) lock = 1'b1;
    count_sys(1'b0, n);
    chk("t3_release_latency", n, SS + ST + 1);

    // 5: soft_reset coinciding with a lock timeout.
    @(negedge clkin) lock = 1'b0;
    wait_pll(1'b1, "t5_retry");
    chk("t5_retry_before", retry_cnt, 4);
    wait_pll(1'b0, "t5_fall");
    repeat (TO - 1) @(posedge clkin);
    #1 soft_reset = 1'b1;
    @(posedge clkin);
    #1 soft_reset = 1'b0;
    chk("t5_retry_cleared", retry_cnt, 0);
    chk("t5_terr_cleared", timeout_err, 0);
    chk("t5_pll_reset", pll_reset, 1);
`ifdef PLL_LOSS_CNT_EN
    chk("t5_loss_cleared", loss_cnt, 0);
`endif
    n = 0;
    do begin @(posedge clkin); #1; n++; end while (pll_reset !== 1'b0 && n < 200);
    chk("t5_restart_width", n, PR);

    // 6: async reset while qualifying lock.
    wait_pll(1'b1, "t6_retry");
    chk("t6_terr_set", timeout_err, 1);
    wait_pll(1'b0, "t6_fall");
    @(negedge clkin) lock = 1'b1;
    @(posedge clkin);
    repeat (3) @(posedge clkin);
    #1 chk("t6_pre_pll_low", pll_reset, 0);
    #1 reset = 1'b1;
    #1;
    chk("t6_pll_reset", pll_reset, 1);
    chk("t6_sys_reset", sys_reset, 1);
    chk("t6_ready", ready, 0);
    chk("t6_terr", timeout_err, 0);
    chk("t6_retry", retry_cnt, 0);
    @(negedge clkin) begin reset = 1'b0; lock = 1'b0; end
    repeat (5) @(posedge clkin);
    @(negedge clkin);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
